// File: rtl/noc_pkg.sv
// Shared definitions for the NoC injection scheduler: flit field positions,
// index-width helpers, header layout and the scheduler state encoding.
package noc_pkg;

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   // Index width that stays legal for single-entry vectors.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Header field positions counted from the top of the flit.
   function automatic int valid_pos(input int width);
      return width - 1;
   endfunction
   function automatic int head_pos(input int width);
      return width - 2;
   endfunction
   function automatic int tail_pos(input int width);
      return width - 3;
   endfunction
   function automatic int vc_pos(input int width);
      return width - 4;
   endfunction
   function automatic int dest_pos(input int width, input int vcw);
      return width - 4 - vcw;
   endfunction

   // Header layout for the default build (2 VCs, 16 nodes); payload follows below it.
   localparam int DEF_VCW = 1;
   localparam int DEF_AW  = 4;

   typedef struct packed {
      logic               valid;
      logic               head;
      logic               tail;
      logic [DEF_VCW-1:0] vc;
      logic [DEF_AW-1:0]  dest;
   } flit_hdr_t;

endpackage

// File: rtl/noc_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer; the
// pointer moves past the winner only when the caller reports the grant taken.
module noc_rr_arbiter
   import noc_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IW      = idx_w(NUM_REQ)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               accept,
   output logic [NUM_REQ-1:0] grant,
   output logic [IW-1:0]      grant_idx,
   output logic               any
);

   logic [IW-1:0] ptr;

   // Scan from the farthest offset down so the nearest request to ptr wins.
   always_comb begin
      int j;
      j         = 0;
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         j = (int'(ptr) + i) % NUM_REQ;
         if (req[j]) begin
            grant     = '0;
            grant[j]  = 1'b1;
            grant_idx = IW'(j);
            any       = 1'b1;
         end
      end
   end

   // Pointer advances to one past the accepted winner.
   always_ff @(posedge clk) begin
      if (!reset)
         ptr <= '0;
      else if (accept)
         ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
   end

endmodule

// File: rtl/noc_inject_scheduler.sv
// Shares one NoC injection port among NUM_REQ requesters: packet-level
// round-robin, one VC per packet, per-VC credit tracking, registered flit out.
module noc_inject_scheduler
   import noc_pkg::*;
#(
   parameter  int WIDTH    = 128,
   parameter  int N        = 16,
   parameter  int NUM_VC   = 2,
   parameter  int NUM_REQ  = 4,
   parameter  int VC_DEPTH = 8,
   localparam int AW       = idx_w(N),
   localparam int VCW      = idx_w(NUM_VC),
   localparam int PW       = WIDTH - 3 - VCW - AW,
   localparam int IW       = idx_w(NUM_REQ),
   localparam int CW       = $clog2(VC_DEPTH + 1)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ-1:0]          req_head,
   input  logic [NUM_REQ-1:0]          req_tail,
   input  logic [NUM_REQ-1:0][AW-1:0]  req_dest,
   input  logic [NUM_REQ-1:0][PW-1:0]  req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic [WIDTH-1:0]            o_flit_out,
   input  logic [NUM_VC-1:0]           credits_in,
   output logic                        busy,
   output logic                        credit_err
);

   state_t                    state, state_nxt;
   logic [IW-1:0]             lock_owner;
   logic [VCW-1:0]            lock_vc;
   logic [AW-1:0]             lock_dest;
   logic [NUM_VC-1:0][CW-1:0] credit;
   logic                      vc_ok;
   logic [VCW-1:0]            free_vc;
   logic [NUM_REQ-1:0]        arb_req, arb_grant;
   logic [IW-1:0]             arb_idx;
   logic                      arb_any;
   logic                      accept, head_acc;
   logic [IW-1:0]             sel_req;
   logic [VCW-1:0]            sel_vc;
   logic [AW-1:0]             sel_dest;
   logic [NUM_VC-1:0]         vc_dec;
   logic [WIDTH-1:0]          flit_nxt;

   // Lowest-index VC that still has downstream space.
   always_comb begin
      vc_ok   = 1'b0;
      free_vc = '0;
      for (int v = NUM_VC - 1; v >= 0; v--) begin
         if (credit[v] != '0) begin
            vc_ok   = 1'b1;
            free_vc = VCW'(v);
         end
      end
   end

   // Only heads compete, and only while a VC can be allocated.
   assign arb_req = (state == IDLE && vc_ok) ? (req_valid & req_head) : '0;

   noc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk       (clk),
      .reset     (reset),
      .req       (arb_req),
      .accept    (head_acc),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .any       (arb_any)
   );

   // Next state, ready and the source of the flit being accepted.
   always_comb begin
      state_nxt = state;
      req_ready = '0;
      sel_req   = lock_owner;
      sel_vc    = lock_vc;
      sel_dest  = lock_dest;
      head_acc  = 1'b0;
      case (state)
         IDLE: begin
            req_ready = arb_grant;
            sel_req   = arb_idx;
            sel_vc    = free_vc;
            sel_dest  = req_dest[arb_idx];
            head_acc  = arb_any;
            if (arb_any && !req_tail[arb_idx])
               state_nxt = SEND;
         end
         SEND: begin
            // A head seen here is treated as body: the owner stays locked.
            if (credit[lock_vc] != '0)
               req_ready[lock_owner] = 1'b1;
            if (req_valid[lock_owner] && req_ready[lock_owner] && req_tail[lock_owner])
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign accept = |(req_valid & req_ready);
   assign busy   = (state == SEND);

   // Which VC counter the accepted flit consumes.
   always_comb begin
      for (int v = 0; v < NUM_VC; v++)
         vc_dec[v] = accept && (sel_vc == VCW'(v));
   end

   // State register plus packet lock captured on the accepted head.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         lock_owner <= '0;
         lock_vc    <= '0;
         lock_dest  <= '0;
      end else begin
         state <= state_nxt;
         if (head_acc) begin
            lock_owner <= arb_idx;
            lock_vc    <= free_vc;
            lock_dest  <= req_dest[arb_idx];
         end
      end
   end

   // Per-VC credits: send and return together cancel; over-return saturates and flags.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int v = 0; v < NUM_VC; v++)
            credit[v] <= CW'(VC_DEPTH);
         credit_err <= 1'b0;
      end else begin
         for (int v = 0; v < NUM_VC; v++) begin
            case ({credits_in[v], vc_dec[v]})
               2'b10: begin
                  if (credit[v] == CW'(VC_DEPTH))
                     credit_err <= 1'b1;
                  else
                     credit[v] <= credit[v] + 1'b1;
               end
               2'b01:   credit[v] <= credit[v] - 1'b1;
               default: ;
            endcase
         end
      end
   end

   // Assemble the outgoing flit: header from lock/arbiter, payload from requester.
   always_comb begin
      flit_nxt                               = '0;
      flit_nxt[valid_pos(WIDTH)]             = 1'b1;
      flit_nxt[head_pos(WIDTH)]              = req_head[sel_req];
      flit_nxt[tail_pos(WIDTH)]              = req_tail[sel_req];
      flit_nxt[vc_pos(WIDTH) -: VCW]         = sel_vc;
      flit_nxt[dest_pos(WIDTH, VCW) -: AW]   = sel_dest;
      flit_nxt[PW-1:0]                       = req_data[sel_req];
   end

   // One-cycle registered output; idle cycles drive all zeros.
   always_ff @(posedge clk) begin
      if (!reset)
         o_flit_out <= '0;
      else
         o_flit_out <= accept ? flit_nxt : '0;
   end

endmodule
